// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus-side controller: register map, status
// bit positions and the reset baud divisor.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int STAT_HOLD_VALID = 0;
    localparam int STAT_TBR        = 1;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_TX_DROP    = 3;

    // 50 MHz / (16 x 9600) - 1, giving a period of divisor+1 cycles
    localparam logic [15:0] DEFAULT_DIV = 16'd325;

    function automatic logic [7:0] pack_status(input logic hold_valid,
                                               input logic tbr,
                                               input logic overrun,
                                               input logic tx_drop);
        logic [7:0] s;
        s                  = 8'h00;
        s[STAT_HOLD_VALID] = hold_valid;
        s[STAT_TBR]        = tbr;
        s[STAT_OVERRUN]    = overrun;
        s[STAT_TX_DROP]    = tx_drop;
        return s;
    endfunction

endpackage

// File: rtl/spart_if.sv
// Processor I/O bus as seen by the SPART controller.
// iocs acts as valid; the slave is always ready, so every cycle with iocs=1
// is one complete access and read data lands in bus_rdata at the closing edge.
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    modport master (output iocs, output iorw, output ioaddr, output bus_wdata,
                    input  bus_rdata);
    modport slave  (input  iocs, input  iorw, input  ioaddr, input  bus_wdata,
                    output bus_rdata);
endinterface

// File: rtl/spart_brg.sv
// 16x-oversample baud enable generator: staged/active divisor and a down
// counter that pulses brg_en once every divisor+1 cycles.
module spart_brg #(
    parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_lo,
    input  logic       wr_hi,
    input  logic [7:0] wdata,
    output logic [7:0] staged_lo,
    output logic [7:0] staged_hi,
    output logic       brg_en
);
    import spart_pkg::*;

    logic [15:0] div_q;
    logic [15:0] count_q;
    logic [15:0] new_div;

    // The high-byte write is the commit, so the new high byte comes straight off the bus
    assign new_div = {wdata, staged_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            staged_lo <= DEFAULT_DIV[7:0];
            staged_hi <= DEFAULT_DIV[15:8];
            div_q     <= DEFAULT_DIV;
            count_q   <= DEFAULT_DIV;
            brg_en    <= 1'b0;
        end else begin
            if (wr_lo) begin
                staged_lo <= wdata;
            end
            if (wr_hi) begin
                staged_hi <= wdata;
                div_q     <= new_div;
                count_q   <= new_div;
                brg_en    <= 1'b0;
            end else if (div_q == 16'd0) begin
                count_q <= 16'd0;
                brg_en  <= 1'b0;
            end else if (count_q == 16'd0) begin
                count_q <= div_q;
                brg_en  <= 1'b1;
            end else begin
                count_q <= count_q - 16'd1;
                brg_en  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spart_ctrl.sv
// SPART bus-side controller: register decode, RX hold register with overrun
// detection, TX load sequencing, and the baud enable generator.
module spart_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    spart_if.slave     bus,
    input  logic       rda,
    input  logic [7:0] rx_data,
    output logic       clear_rda,
    input  logic       tbr,
    output logic       tx_load,
    output logic [7:0] tx_data,
    output logic       brg_en
);
    import spart_pkg::*;

    logic       rda_q;
    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic       overrun_q;
    logic       tx_drop_q;
    logic [7:0] staged_lo;
    logic [7:0] staged_hi;

    logic       rda_rise;
    logic       rd_data, wr_data, wr_stat, wr_dbl, wr_dbh;
    logic [7:0] status;
    logic [7:0] rd_mux;

    assign rda_rise = rda & ~rda_q;
    assign rd_data  = bus.iocs &  bus.iorw & (bus.ioaddr == ADDR_DATA);
    assign wr_data  = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_DATA);
    assign wr_stat  = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_STAT);
    assign wr_dbl   = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_DBL);
    assign wr_dbh   = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_DBH);

    assign status = pack_status(hold_valid_q, tbr, overrun_q, tx_drop_q);

    always_comb begin
        rd_mux = 8'h00;
        case (bus.ioaddr)
            ADDR_DATA: rd_mux = hold_q;
            ADDR_STAT: rd_mux = status;
            ADDR_DBL:  rd_mux = staged_lo;
            ADDR_DBH:  rd_mux = staged_hi;
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rda_q         <= 1'b0;
            hold_q        <= 8'h00;
            hold_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            tx_drop_q     <= 1'b0;
            bus.bus_rdata <= 8'h00;
            clear_rda     <= 1'b0;
            tx_load       <= 1'b0;
            tx_data       <= 8'h00;
        end else begin
            rda_q     <= rda;
            clear_rda <= rd_data;
            tx_load   <= wr_data & tbr;

            if (bus.iocs && bus.iorw) begin
                bus.bus_rdata <= rd_mux;
            end

            // A new byte always wins over a consuming read in the same cycle
            if (rda_rise) begin
                hold_q       <= rx_data;
                hold_valid_q <= 1'b1;
            end else if (rd_data) begin
                hold_valid_q <= 1'b0;
            end

            // Sticky flags: a set in the same cycle as a W1C clear wins
            if (rda_rise && hold_valid_q && !rd_data) begin
                overrun_q <= 1'b1;
            end else if (wr_stat && bus.bus_wdata[STAT_OVERRUN]) begin
                overrun_q <= 1'b0;
            end

            if (wr_data && !tbr) begin
                tx_drop_q <= 1'b1;
            end else if (wr_stat && bus.bus_wdata[STAT_TX_DROP]) begin
                tx_drop_q <= 1'b0;
            end

            if (wr_data && tbr) begin
                tx_data <= bus.bus_wdata;
            end
        end
    end

    spart_brg #(
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_brg (
        .clk       (clk),
        .rst       (rst),
        .wr_lo     (wr_dbl),
        .wr_hi     (wr_dbh),
        .wdata     (bus.bus_wdata),
        .staged_lo (staged_lo),
        .staged_hi (staged_hi),
        .brg_en    (brg_en)
    );

endmodule

// File: tb/tb_spart_ctrl.sv
// Directed bench for spart_ctrl: a table of single-cycle accesses with
// hand-computed results plus sequences for baud timing and reset.
module tb_spart_ctrl;
    import spart_pkg::*;

    logic       clk;
    logic       rst;
    logic       rda;
    logic [7:0] rx_data;
    logic       clear_rda;
    logic       tbr;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       brg_en;

    spart_if bus ();

    spart_ctrl #(.DEFAULT_DIV(16'd325)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .rda       (rda),
        .rx_data   (rx_data),
        .clear_rda (clear_rda),
        .tbr       (tbr),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .brg_en    (brg_en)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && tx_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got tx_load with tx_data %0h expected no pulse", tx_data);
            end else begin
                check("tx_data", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd);
        bus.iocs      = cs;
        bus.iorw      = rw;
        bus.ioaddr    = a;
        bus.bus_wdata = wd;
        @(posedge clk);
        #1;
        bus.iocs = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (brg_en === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       cs;
        logic       rw;
        logic [1:0] a;
        logic [7:0] wd;
        logic       r;
        logic [7:0] rx;
        logic       t;
        logic       chk;
        logic [7:0] er;
        logic       el;
        logic [7:0] et;
        logic       ec;
    } row_t;

    row_t vec[$];

    function automatic row_t mk(string n, logic cs, logic rw, logic [1:0] a, logic [7:0] wd,
                                logic r, logic [7:0] rx, logic t,
                                logic chk, logic [7:0] er, logic el, logic [7:0] et, logic ec);
        row_t v;
        v.name = n; v.cs = cs; v.rw = rw; v.a = a; v.wd = wd;
        v.r = r; v.rx = rx; v.t = t;
        v.chk = chk; v.er = er; v.el = el; v.et = et; v.ec = ec;
        return v;
    endfunction

    initial begin
        int n;
        int pulses;

        rst = 1'b1; rda = 1'b0; rx_data = 8'h00; tbr = 1'b1;
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.bus_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_rdata", {8'h00, bus.bus_rdata}, 16'h0000);
        check("rst_tx_data",   {8'h00, tx_data},       16'h0000);
        check("rst_tx_load",   {15'h0, tx_load},       16'h0000);
        check("rst_clear_rda", {15'h0, clear_rda},     16'h0000);
        check("rst_brg_en",    {15'h0, brg_en},        16'h0000);
        rst = 1'b0;

        wait_pulse(400, n);
        check("brg_first_seen", {15'h0, (n > 0)}, 16'h0001);
        wait_pulse(400, n);
        check("brg_period_default", n[15:0], 16'd326);

        //        name            cs   rw   addr       wd     rda  rx     tbr  chk  exp_rd  load et     clr
        vec.push_back(mk("stat_idle",    1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 0));
        vec.push_back(mk("tx_a5",        1, 0, ADDR_DATA, 8'hA5, 0, 8'h00, 1, 0, 8'h00, 1, 8'hA5, 0));
        vec.push_back(mk("tx_a5_after",  0, 0, ADDR_DATA, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("tx_drop",      1, 0, ADDR_DATA, 8'h5A, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("stat_drop_b",  1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 0, 1, 8'h08, 0, 8'h00, 0));
        vec.push_back(mk("stat_drop",    1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h0A, 0, 8'h00, 0));
        vec.push_back(mk("w1c_drop",     1, 0, ADDR_STAT, 8'h08, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("stat_clr",     1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 0));
        vec.push_back(mk("rx_3c_edge",   0, 0, ADDR_DATA, 8'h00, 1, 8'h3C, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("stat_rx",      1, 1, ADDR_STAT, 8'h00, 1, 8'h3C, 1, 1, 8'h03, 0, 8'h00, 0));
        vec.push_back(mk("read_3c",      1, 1, ADDR_DATA, 8'h00, 1, 8'h3C, 1, 1, 8'h3C, 0, 8'h00, 1));
        vec.push_back(mk("clr_once",     0, 0, ADDR_DATA, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("stat_empty",   1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 0));
        vec.push_back(mk("ovr_edge1",    0, 0, ADDR_DATA, 8'h00, 1, 8'h11, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("ovr_low",      0, 0, ADDR_DATA, 8'h00, 0, 8'h11, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("ovr_edge2",    0, 0, ADDR_DATA, 8'h00, 1, 8'h22, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("stat_ovr",     1, 1, ADDR_STAT, 8'h00, 1, 8'h22, 1, 1, 8'h07, 0, 8'h00, 0));
        vec.push_back(mk("read_22",      1, 1, ADDR_DATA, 8'h00, 1, 8'h22, 1, 1, 8'h22, 0, 8'h00, 1));
        vec.push_back(mk("w1c_ovr",      1, 0, ADDR_STAT, 8'h04, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("stat_ovr_clr", 1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 0));
        vec.push_back(mk("sim_edge1",    0, 0, ADDR_DATA, 8'h00, 1, 8'h11, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("sim_low",      0, 0, ADDR_DATA, 8'h00, 0, 8'h11, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("sim_read_11",  1, 1, ADDR_DATA, 8'h00, 1, 8'h22, 1, 1, 8'h11, 0, 8'h00, 1));
        vec.push_back(mk("sim_stat",     1, 1, ADDR_STAT, 8'h00, 1, 8'h22, 1, 1, 8'h03, 0, 8'h00, 0));
        vec.push_back(mk("sim_read_22",  1, 1, ADDR_DATA, 8'h00, 1, 8'h22, 1, 1, 8'h22, 0, 8'h00, 1));
        vec.push_back(mk("sim_stat_end", 1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 0));
        vec.push_back(mk("sw_edge1",     0, 0, ADDR_DATA, 8'h00, 1, 8'h33, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("sw_low",       0, 0, ADDR_DATA, 8'h00, 0, 8'h33, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("sw_w1c_edge",  1, 0, ADDR_STAT, 8'h0C, 1, 8'h44, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("sw_stat_set",  1, 1, ADDR_STAT, 8'h00, 1, 8'h44, 1, 1, 8'h07, 0, 8'h00, 0));
        vec.push_back(mk("sw_w1c_ff",    1, 0, ADDR_STAT, 8'hFF, 1, 8'h44, 1, 0, 8'h00, 0, 8'h00, 0));
        vec.push_back(mk("sw_stat_keep", 1, 1, ADDR_STAT, 8'h00, 1, 8'h44, 1, 1, 8'h03, 0, 8'h00, 0));
        vec.push_back(mk("sw_read_44",   1, 1, ADDR_DATA, 8'h00, 1, 8'h44, 1, 1, 8'h44, 0, 8'h00, 1));
        vec.push_back(mk("sw_stat_end",  1, 1, ADDR_STAT, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0, 8'h00, 0));
        vec.push_back(mk("read_dbl_rst", 1, 1, ADDR_DBL,  8'h00, 0, 8'h00, 1, 1, 8'h45, 0, 8'h00, 0));
        vec.push_back(mk("read_dbh_rst", 1, 1, ADDR_DBH,  8'h00, 0, 8'h00, 1, 1, 8'h01, 0, 8'h00, 0));

        foreach (vec[i]) begin
            rda     = vec[i].r;
            rx_data = vec[i].rx;
            tbr     = vec[i].t;
            if (vec[i].el) exp_q.push_back(vec[i].et);
            drive(vec[i].cs, vec[i].rw, vec[i].a, vec[i].wd);
            check({vec[i].name, "_load"}, {15'h0, tx_load},   {15'h0, vec[i].el});
            check({vec[i].name, "_clr"},  {15'h0, clear_rda}, {15'h0, vec[i].ec});
            if (vec[i].chk) check({vec[i].name, "_rdata"}, {8'h00, bus.bus_rdata}, {8'h00, vec[i].er});
        end
        rda = 1'b0; tbr = 1'b1;

        // divisor 3 -> period 4 from the commit onward
        drive(1, 0, ADDR_DBL, 8'h03);
        drive(1, 0, ADDR_DBH, 8'h00);
        check("commit_no_pulse", {15'h0, brg_en}, 16'h0000);
        wait_pulse(20, n);
        check("div3_first", n[15:0], 16'd4);
        wait_pulse(20, n);
        check("div3_period_a", n[15:0], 16'd4);
        wait_pulse(20, n);
        check("div3_period_b", n[15:0], 16'd4);
        drive(1, 1, ADDR_DBL, 8'h00);
        check("read_dbl_3", {8'h00, bus.bus_rdata}, 16'h0003);
        drive(1, 1, ADDR_DBH, 8'h00);
        check("read_dbh_0", {8'h00, bus.bus_rdata}, 16'h0000);

        // commit landing on the count=0 edge suppresses that pulse
        wait_pulse(20, n);
        check("cz_sync", {15'h0, (n > 0)}, 16'h0001);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drive(1, 0, ADDR_DBH, 8'h00);
        check("cz_commit_wins", {15'h0, brg_en}, 16'h0000);
        wait_pulse(20, n);
        check("cz_after", n[15:0], 16'd4);

        // divisor 0 stops the generator
        drive(1, 0, ADDR_DBL, 8'h00);
        drive(1, 0, ADDR_DBH, 8'h00);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (brg_en === 1'b1) pulses++;
        end
        check("div0_no_pulses", pulses[15:0], 16'd0);

        // reset arriving with a TX write in flight
        rda = 1'b1; rx_data = 8'h77;
        drive(0, 0, ADDR_DATA, 8'h00);
        rda = 1'b0; tbr = 1'b0;
        drive(1, 0, ADDR_DATA, 8'h11);
        tbr = 1'b1;
        rst = 1'b1;
        drive(1, 0, ADDR_DATA, 8'h99);
        rst = 1'b0;
        check("mid_rst_tx_load", {15'h0, tx_load},       16'h0000);
        check("mid_rst_tx_data", {8'h00, tx_data},       16'h0000);
        check("mid_rst_rdata",   {8'h00, bus.bus_rdata}, 16'h0000);
        check("mid_rst_brg",     {15'h0, brg_en},        16'h0000);
        drive(0, 0, ADDR_DATA, 8'h00);
        check("mid_rst_no_load", {15'h0, tx_load}, 16'h0000);
        drive(1, 1, ADDR_STAT, 8'h00);
        check("mid_rst_stat", {8'h00, bus.bus_rdata}, 16'h0002);
        drive(1, 1, ADDR_DATA, 8'h00);
        check("mid_rst_hold", {8'h00, bus.bus_rdata}, 16'h0000);
        drive(1, 1, ADDR_DBL, 8'h00);
        check("mid_rst_dbl", {8'h00, bus.bus_rdata}, 16'h0045);
        drive(1, 1, ADDR_DBH, 8'h00);
        check("mid_rst_dbh", {8'h00, bus.bus_rdata}, 16'h0001);
        wait_pulse(400, n);
        check("mid_rst_brg_seen", {15'h0, (n > 0)}, 16'h0001);
        wait_pulse(400, n);
        check("mid_rst_brg_period", n[15:0], 16'd326);

        check("tx_queue_empty", exp_q.size(), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_ctrl.md
# spart_ctrl

Bus-side controller for the SPART. It decodes processor I/O accesses and sequences the receive and transmit datapaths. It also captures received bytes into a holding register with overrun detection, and owns the 16x-oversample baud enable generator that paces the receiver and transmitter. It sits between the processor I/O bus and the rx/tx SPART cores.

## Interface
Parameters:
- DEFAULT_DIV, 16'd325: baud divisor loaded at reset (50 MHz / (16 × 9600)).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- iocs  in  1  access strobe; every cycle with iocs=1 is one complete access
- iorw  in  1  1 = read, 0 = write
- ioaddr  in  2  register select
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data, registered
- rda  in  1  receiver byte-ready level
- rx_data  in  8  receiver shift register
- clear_rda  out  1  one-cycle pulse to receiver
- tbr  in  1  transmitter buffer ready
- tx_load  out  1  one-cycle load pulse to transmitter
- tx_data  out  8  byte for transmitter; valid with tx_load
- brg_en  out  1  one-cycle pulse at 1/16 bit time

## Operation
Address map:
- 00 write: TX byte. 00 read: RX hold byte.
- 01 read: status. Bit0 = hold_valid, bit1 = tbr, bit2 = overrun (sticky), bit3 = tx_drop (sticky), bits 7:4 = 0. 01 write: write-1-to-clear on bits 2 and 3.
- 10 read/write: staged divisor low byte.
- 11 read/write: staged divisor high byte. Writing 11 commits {staged_hi, staged_lo} to the active divisor.

RX capture:
- rda rising edge (rda=1, previous cycle's rda=0): rx_data is copied to hold and hold_valid is set.
- If hold_valid was already 1 and was not consumed in the same cycle, overrun is also set. The new byte overwrites hold.
- Read of 00: bus_rdata is loaded with hold, hold_valid is cleared, and clear_rda pulses the next cycle.

TX:
- Write 00 with tbr=1: tx_data is loaded with bus_wdata and tx_load pulses the next cycle.
- Write 00 with tbr=0: no pulse, tx_data is unchanged, tx_drop is set.

Baud generator:
- 16-bit down counter. When count=0, brg_en pulses and the counter reloads the active divisor; otherwise the counter decrements.
- The period is therefore divisor+1 cycles.
- Active divisor 0: brg_en is held at 0 and the counter is held at 0.
- A commit (write to 11) reloads the counter with the new divisor in the same edge and suppresses that cycle's brg_en.

Reads of undefined bits and of write-only effects return 0. A write to 01 never changes bits 0 and 1.

## Timing
- Reset values:
  - Outputs: bus_rdata 0, tx_data 0, tx_load 0, clear_rda 0, brg_en 0.
  - Internal: hold 0, hold_valid 0, overrun 0, tx_drop 0, staged bytes = DEFAULT_DIV, active divisor = DEFAULT_DIV, counter = DEFAULT_DIV. The rda edge register resets to 0.
- Read latency is 1 cycle: bus_rdata is updated at the edge ending the access cycle and holds until the next read.
- Status reads return the values from before that edge.
- Side effects (clear_rda, tx_load) appear 1 cycle after the access cycle.
- Back-to-back accesses are allowed with no wait states.
- Simultaneous events:
  - Read 00 in the same cycle as an rda rising edge with hold_valid=1: the read returns the old byte, hold takes the new byte, hold_valid stays 1, overrun is not set, and clear_rda still pulses.
  - W1C write in the same cycle as a sticky-flag set: set wins.
  - Commit in a cycle where count=0: the commit wins and brg_en stays 0.
- rst mid-operation: all state returns to reset values at the next edge, and any in-flight pulse is dropped.

## Structure
- spart_pkg holds:
  - Address constants: ADDR_DATA=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11.
  - Status bit indices.
  - DEFAULT_DIV.
- Sub-module spart_brg contains the divisor register, the down counter, commit/reload and brg_en generation.
- spart_ctrl contains decode, hold/flags, rda edge detect and pulse registers.

## Test plan
- Reset, then idle: brg_en pulses every 326 cycles and status reads 8'h02 while tbr=1.
- Write 8'hA5 to 00 with tbr=1: exactly one tx_load pulse with tx_data=A5. Repeating the write with tbr=0 gives no pulse and status bit3=1. Writing 8'h08 to 01 clears bit3.
- Drive rx_data=8'h3C and an rda rising edge: status reads 8'h03. Read 00 returns 3C, clear_rda pulses once, and status then reads 8'h02.
- Two rda rising edges (bytes 11 then 22) without a read: status bit2=1 and a read of 00 returns 22. Repeat with the read of 00 in the same cycle as the second edge: the read returns 11, no overrun is set, and hold=22.
- Write 10=8'h03 then 11=8'h00: brg_en period becomes 4 cycles starting after the commit. Write divisor 0: brg_en stops.
- Assert rst between a write-00 cycle and its tx_load pulse: no pulse occurs and all registers return to their reset values.
